// File: rtl/sos_pkg.sv
// Shared definitions for the SOS generator/decoder pair: state encodings,
// the SOS symbol pattern and the default unit timing so both sides agree.
package sos_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2
    } sos_state_e;

    // Symbol window: dot = 0, dash = 1, newest symbol at bit 0.
    localparam int             SOS_LEN     = 9;
    localparam logic [8:0]     SOS_PATTERN = 9'b000111000;
    localparam int             SYM_CNT_W   = 4;

    // Default timing, in unit ticks unless noted.
    localparam int UNIT_CYC_DEF  = 50000;  // clock cycles per unit tick
    localparam int DOT_MAX_T_DEF = 150;
    localparam int GLITCH_T_DEF  = 10;
    localparam int GAP_T_DEF     = 700;
    localparam int CNT_W_DEF     = 10;

    // A word is SOS only with exactly nine symbols, no overflow, right pattern.
    function automatic logic is_sos_word(
        input logic [SYM_CNT_W-1:0] cnt,
        input logic                 ovf,
        input logic [SOS_LEN-1:0]   win
    );
        return (cnt == SYM_CNT_W'(SOS_LEN)) && !ovf && (win == SOS_PATTERN);
    endfunction

endpackage

// File: rtl/sos_unit_tick.sv
// Unit-tick prescaler: pulses o_tick once every UNIT_CYC clocks and can be
// restarted synchronously so a new mark/space is timed from its first cycle.
module sos_unit_tick
    import sos_pkg::*;
#(
    parameter int UNIT_CYC = UNIT_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_tick
);

    localparam int                PRE_W  = (UNIT_CYC > 1) ? $clog2(UNIT_CYC) : 1;
    localparam logic [PRE_W-1:0]  L_LAST = PRE_W'(UNIT_CYC - 1);

    logic [PRE_W-1:0] r_pre;

    // Free-running cycle counter, wrapping at UNIT_CYC-1 or forced to 0 on restart.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pre <= '0;
        end else if (i_restart) begin
            r_pre <= '0;
        end else if (r_pre == L_LAST) begin
            r_pre <= '0;
        end else begin
            r_pre <= r_pre + PRE_W'(1'b1);
        end
    end

    assign o_tick = (r_pre == L_LAST);

endmodule

// File: rtl/sos_decode_module.sv
// Morse receiver: times marks and spaces of a keyed line in unit ticks,
// classifies marks as dot/dash and flags a complete "...---..." word.
module sos_decode_module
    import sos_pkg::*;
#(
    parameter int UNIT_CYC  = UNIT_CYC_DEF,
    parameter int DOT_MAX_T = DOT_MAX_T_DEF,
    parameter int GLITCH_T  = GLITCH_T_DEF,
    parameter int GAP_T     = GAP_T_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic Start_Sig,
    input  logic Key_In,
    output logic Sym_Valid,
    output logic Sym_Is_Dash,
    output logic Done_Sig
);

    localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] L_DOT_MAX = CNT_W'(DOT_MAX_T);
    localparam logic [CNT_W-1:0] L_GLITCH  = CNT_W'(GLITCH_T);
    localparam logic [CNT_W-1:0] L_GAP     = CNT_W'(GAP_T);

    logic                 r_key_meta;
    logic                 r_key_s;
    sos_state_e           r_state;
    logic [CNT_W-1:0]     r_tick_cnt;
    logic [SOS_LEN-1:0]   r_window;
    logic [SYM_CNT_W-1:0] r_sym_cnt;
    logic                 r_ovf;
    logic                 r_sym_valid;
    logic                 r_sym_is_dash;
    logic                 r_done;

    logic                 w_tick;
    logic                 w_restart;
    logic [CNT_W-1:0]     w_cnt_next;
    logic                 w_gap;
    logic                 w_is_dash;
    logic                 w_keep_mark;

    sos_unit_tick #(
        .UNIT_CYC (UNIT_CYC)
    ) u_unit_tick (
        .i_clk     (CLK),
        .i_rst_n   (RSTn),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    // Two-flop synchroniser for the asynchronous key line.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_key_meta <= 1'b0;
            r_key_s    <= 1'b0;
        end else begin
            r_key_meta <= Key_In;
            r_key_s    <= r_key_meta;
        end
    end

    // Elapsed-tick count including a tick landing this cycle, plus state-change detect.
    always_comb begin
        w_cnt_next = r_tick_cnt;
        if (w_tick && (r_tick_cnt != L_CNT_MAX)) begin
            w_cnt_next = r_tick_cnt + CNT_W'(1'b1);
        end else begin
            w_cnt_next = r_tick_cnt;
        end
        w_gap       = (w_cnt_next >= L_GAP);
        w_is_dash   = (w_cnt_next > L_DOT_MAX);
        w_keep_mark = (w_cnt_next >= L_GLITCH);
        w_restart   = 1'b0;
        if (!Start_Sig) begin
            w_restart = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE:  w_restart = r_key_s;
                ST_MARK:  w_restart = ~r_key_s;
                ST_SPACE: w_restart = r_key_s | w_gap;
                default:  w_restart = 1'b1;
            endcase
        end
    end

    // Receiver FSM with tick counter, symbol window and registered pulse outputs.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state       <= ST_IDLE;
            r_tick_cnt    <= '0;
            r_window      <= '0;
            r_sym_cnt     <= '0;
            r_ovf         <= 1'b0;
            r_sym_valid   <= 1'b0;
            r_sym_is_dash <= 1'b0;
            r_done        <= 1'b0;
        end else if (!Start_Sig) begin
            r_state       <= ST_IDLE;
            r_tick_cnt    <= '0;
            r_window      <= '0;
            r_sym_cnt     <= '0;
            r_ovf         <= 1'b0;
            r_sym_valid   <= 1'b0;
            r_sym_is_dash <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_sym_valid   <= 1'b0;
            r_sym_is_dash <= 1'b0;
            r_done        <= 1'b0;
            // Any state change restarts timing; otherwise keep counting.
            r_tick_cnt    <= w_restart ? '0 : w_cnt_next;
            case (r_state)
                ST_IDLE: begin
                    r_state <= r_key_s ? ST_MARK : ST_IDLE;
                end
                ST_MARK: begin
                    if (!r_key_s) begin
                        r_state <= ST_SPACE;
                        // Marks shorter than the glitch limit leave no trace.
                        if (w_keep_mark) begin
                            r_sym_valid   <= 1'b1;
                            r_sym_is_dash <= w_is_dash;
                            r_window      <= {r_window[SOS_LEN-2:0], w_is_dash};
                            if (r_sym_cnt == SYM_CNT_W'(SOS_LEN)) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_sym_cnt <= r_sym_cnt + SYM_CNT_W'(1'b1);
                            end
                        end
                    end else begin
                        r_state <= ST_MARK;
                    end
                end
                ST_SPACE: begin
                    if (w_gap) begin
                        // Word end wins over a simultaneous new mark, which then starts directly.
                        r_done    <= is_sos_word(r_sym_cnt, r_ovf, r_window);
                        r_window  <= '0;
                        r_sym_cnt <= '0;
                        r_ovf     <= 1'b0;
                        r_state   <= r_key_s ? ST_MARK : ST_IDLE;
                    end else if (r_key_s) begin
                        r_state <= ST_MARK;
                    end else begin
                        r_state <= ST_SPACE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign Sym_Valid   = r_sym_valid;
    assign Sym_Is_Dash = r_sym_is_dash;
    assign Done_Sig    = r_done;

endmodule

// File: tb/tb_sos_decode_module.sv
// Self-checking bench for sos_decode_module: keyed words are generated with
// expected symbol/done events queued, and DUT output pulses are compared
// against the queue front on every falling clock edge.
module tb_sos_decode_module;

    localparam int UC = 4;   // clock cycles per unit tick in this bench

    localparam int EV_DOT  = 0;
    localparam int EV_DASH = 1;
    localparam int EV_DONE = 2;

    logic CLK = 1'b0;
    logic RSTn = 1'b0;
    logic Start_Sig = 1'b0;
    logic Key_In = 1'b0;
    logic Sym_Valid;
    logic Sym_Is_Dash;
    logic Done_Sig;

    int exp_q[$];
    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int done_cyc = -1;
    int fall_cyc = 0;

    sos_decode_module #(
        .UNIT_CYC  (UC),
        .DOT_MAX_T (3),
        .GLITCH_T  (1),
        .GAP_T     (7),
        .CNT_W     (10)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Start_Sig   (Start_Sig),
        .Key_In      (Key_In),
        .Sym_Valid   (Sym_Valid),
        .Sym_Is_Dash (Sym_Is_Dash),
        .Done_Sig    (Done_Sig)
    );

    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    // Advance one cycle; on each output pulse pop the scoreboard and compare.
    task automatic step();
        int obs;
        int exp;
        @(negedge CLK);
        cyc++;
        if (Sym_Valid && Done_Sig) begin
            n_checks++;
            n_fail++;
            $display("FAIL overlap: Sym_Valid=1 Done_Sig=1 at cycle %0d, required not both", cyc);
        end else if (Sym_Valid || Done_Sig) begin
            obs = Done_Sig ? EV_DONE : (Sym_Is_Dash ? EV_DASH : EV_DOT);
            if (Done_Sig) done_cyc = cyc;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard: event %0d at cycle %0d, required no event", obs, cyc);
            end else begin
                exp = exp_q.pop_front();
                if (obs !== exp) begin
                    n_fail++;
                    $display("FAIL scoreboard: event %0d at cycle %0d, required %0d", obs, cyc, exp);
                end
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic key_mark(input int ncyc);
        Key_In = 1'b1;
        wait_cyc(ncyc);
        Key_In = 1'b0;
    endtask

    // One symbol: 2-tick dot or 5-tick dash followed by a 2-tick space.
    task automatic send_sym(input logic dash);
        exp_q.push_back(dash ? EV_DASH : EV_DOT);
        key_mark((dash ? 5 : 2) * UC);
        wait_cyc(2 * UC);
    endtask

    task automatic send_word(input logic [9:0] pat, input int len);
        for (int i = len - 1; i >= 0; i--) send_sym(pat[i]);
    endtask

    // Word gap of 8 ticks plus margin for the done pulse to appear.
    task automatic end_word(input logic expect_done);
        if (expect_done) exp_q.push_back(EV_DONE);
        wait_cyc(8 * UC + 16);
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        Start_Sig = 1'b1;
        Key_In = 1'b1;
        wait_cyc(3);
        n_checks++;
        if ({Sym_Valid, Sym_Is_Dash, Done_Sig} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_hold: outputs %b, required 000", {Sym_Valid, Sym_Is_Dash, Done_Sig});
        end
        Key_In = 1'b0;
        RSTn = 1'b1;
        wait_cyc(4 * UC);
        n_checks++;
        if ({Sym_Valid, Sym_Is_Dash, Done_Sig} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_idle: outputs %b, required 000", {Sym_Valid, Sym_Is_Dash, Done_Sig});
        end
    endtask

    task automatic test_sos();
        logic [8:0] pat;
        pat = 9'b000111000;
        done_cyc = -1;
        for (int i = 8; i >= 1; i--) send_sym(pat[i]);
        exp_q.push_back(EV_DOT);
        key_mark(2 * UC);
        fall_cyc = cyc;
        wait_cyc(2 * UC);
        end_word(1'b1);
        n_checks++;
        if ((done_cyc - fall_cyc) < 28 || (done_cyc - fall_cyc) > 32) begin
            n_fail++;
            $display("FAIL sos_latency: %0d cycles after last fall, required 28..32", done_cyc - fall_cyc);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sos_drain: %0d events pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        send_word(10'b0001110000, 10);
        end_word(1'b0);
        send_word(10'b0000111000, 9);
        end_word(1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL overflow_drain: %0d events pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_glitch();
        logic [8:0] pat;
        pat = 9'b000111000;
        for (int i = 8; i >= 0; i--) begin
            send_sym(pat[i]);
            if (i == 5) begin
                key_mark(2);
                wait_cyc(2 * UC);
            end
        end
        end_word(1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL glitch_drain: %0d events pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_boundary();
        exp_q.push_back(EV_DOT);
        key_mark(3 * UC);
        wait_cyc(2 * UC);
        exp_q.push_back(EV_DASH);
        key_mark(4 * UC);
        wait_cyc(2 * UC);
        end_word(1'b0);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL boundary_drain: %0d events pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_wrong_word();
        send_word(10'b0000111001, 9);
        end_word(1'b0);
        send_word(10'b0000111000, 9);
        end_word(1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL wrong_word_drain: %0d events pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        send_word(10'b0000000001, 4);
        Key_In = 1'b1;
        wait_cyc(3 * UC);
        RSTn = 1'b0;
        #1;
        n_checks++;
        if ({Sym_Valid, Sym_Is_Dash, Done_Sig} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mid_out: outputs %b, required 000", {Sym_Valid, Sym_Is_Dash, Done_Sig});
        end
        Key_In = 1'b0;
        wait_cyc(3);
        RSTn = 1'b1;
        wait_cyc(3 * UC);
        send_word(10'b0000111000, 9);
        end_word(1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL reset_mid_drain: %0d events pending, required 0", exp_q.size());
        end
    endtask

    task automatic test_start_low();
        send_word(10'b0000000111, 5);
        Start_Sig = 1'b0;
        key_mark(5 * UC);
        wait_cyc(2 * UC);
        n_checks++;
        if ({Sym_Valid, Sym_Is_Dash, Done_Sig} !== 3'b000) begin
            n_fail++;
            $display("FAIL start_low_out: outputs %b, required 000", {Sym_Valid, Sym_Is_Dash, Done_Sig});
        end
        Start_Sig = 1'b1;
        wait_cyc(2 * UC);
        send_word(10'b0000111000, 9);
        end_word(1'b1);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL start_low_drain: %0d events pending, required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_sos();
        test_overflow();
        test_glitch();
        test_boundary();
        test_wrong_word();
        test_reset_mid();
        test_start_low();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sos_decode_module.md
Name: sos_decode_module

Overview:
- Morse receiver: the receiving end of the keyed S/O/S sequence our SOS generator path produces.
- Samples one keyed line, measures mark and space lengths in unit ticks, and classifies each mark as dot or dash.
- Keeps a 9-symbol window and pulses Done_Sig when a complete word equal to "...---..." ends.
- Sits beside the SOS generator/controller; used for loopback self-test and as a key-input decoder.

Parameters:
- UNIT_CYC, 50000: CLK cycles per unit tick (1 ms at 50 MHz).
- DOT_MAX_T, 150: a mark of this many ticks or fewer is a dot; a longer mark is a dash.
- GLITCH_T, 10: a mark shorter than this many ticks is discarded.
- GAP_T, 700: a space of this many ticks ends the word.
- CNT_W, 10: width of the tick counter; it saturates at all-ones.

Ports:
- CLK  input  1  system clock
- RSTn  input  1  asynchronous active-low reset
- Start_Sig  input  1  level enable; low forces IDLE and clears all state
- Key_In  input  1  asynchronous key line; 1 = mark
- Sym_Valid  output  1  one-cycle pulse for each accepted symbol
- Sym_Is_Dash  output  1  symbol type, valid while Sym_Valid is high; 1 = dash
- Done_Sig  output  1  one-cycle pulse when an SOS word is recognised

Behaviour:
- Reset:
  - One clock; RSTn is asynchronous and active-low.
  - All outputs are 0 under reset; FSM is IDLE; shift register, symbol count, overflow flag, prescaler and tick counter are all 0.
  - Reset asserted mid-mark or mid-word discards everything in progress.
- Input synchronisation: Key_In passes through a 2-flop synchroniser (key_s); all decisions use key_s.
- Prescaler and tick counter:
  - Prescaler emits tick every UNIT_CYC cycles.
  - Prescaler and tick counter both restart to 0 on every FSM state change.
  - Tick counter increments on tick and saturates.
- FSM:
  - IDLE: key_s=1 -> MARK.
  - MARK: key_s=0 ->
    - if count < GLITCH_T: discard the mark, go to SPACE, count cleared;
    - else emit the symbol and go to SPACE.
  - SPACE:
    - key_s=1 -> MARK;
    - count reaching GAP_T -> word end, then IDLE.
- Symbol emit:
  - Sym_Valid=1 in the cycle after the cycle where key_s is first seen 0 in MARK.
  - Sym_Is_Dash = (count > DOT_MAX_T). Boundary: count==DOT_MAX_T is a dot; DOT_MAX_T+1 is a dash.
  - Symbol shifts into a 9-bit window (dot=0, dash=1, newest at bit 0).
  - sym_cnt increments, saturating at 9; a 10th symbol sets the overflow flag.
- Word end:
  - Done_Sig=1 for exactly one cycle iff sym_cnt==9, overflow==0 and window==9'b000111000.
  - Window, sym_cnt and overflow then clear.
  - If the gap is reached and key_s=1 in the same cycle: word end is processed first (Done may pulse), then the FSM enters MARK directly.
- A word shorter or longer than 9 symbols never produces Done_Sig.
- Start_Sig low: takes effect in the next cycle; same clearing as reset; Sym_Valid and Done_Sig are suppressed. Resuming from Start_Sig=1 always starts in IDLE.
- Sym_Valid and Done_Sig are never high in the same cycle.

Decomposition:
- Shared package sos_pkg:
  - state encodings IDLE/MARK/SPACE;
  - SOS_PATTERN = 9'b000111000;
  - SOS_LEN = 9;
  - default timing constants, so the generator side uses identical unit values.
- One sub-module: sos_unit_tick.
  - Contains the prescaler with a synchronous restart input; outputs tick.
  - Instantiated once.

Test Plan:
Bench uses UNIT_CYC=4, DOT_MAX_T=3, GLITCH_T=1, GAP_T=7; dot = 2-tick mark, dash = 5-tick mark, inter-symbol space = 2 ticks.
- Key "...---..." then an 8-tick space -> 9 Sym_Valid pulses with Sym_Is_Dash 0,0,0,1,1,1,0,0,0, then exactly one Done_Sig pulse, about 28 cycles after the last mark falls.
- Key "...---...." (10 symbols) then a gap -> 10 Sym_Valid pulses, no Done_Sig; a following clean SOS word -> Done_Sig.
- 2-cycle mark (0 ticks) inserted between two SOS symbols -> no extra Sym_Valid; Done_Sig is still produced.
- Marks of exactly 3 and 4 ticks -> Sym_Is_Dash 0 and 1 respectively.
- Key "...---..-" then a gap -> no Done_Sig, window cleared; an immediate next SOS word -> Done_Sig.
- RSTn pulsed low mid-dash (or Start_Sig low mid-word) -> outputs 0 at once; a subsequent full SOS word -> single Done_Sig; no leftover symbols counted.
